// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port dmem between the CPU data port and a DMA master
module dmem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;
    localparam logic [3:0] S_MAX  = 4'(STARVE_MAX);
    localparam logic [3:0] L_MAX  = 4'(LOCK_MAX);
    logic [0:0]        state, state_nx;
    logic [3:0]        starve_cnt, starve_nx, lock_cnt, lock_nx;
    logic              lock_hold, lock_spent, idle_dma, dma_win, cpu_win;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    // grant decision and next-state; a spent lock makes DMA ineligible for one cycle
    always_comb begin
        lock_hold  = (state == LOCKED) & dma_req & dma_lock & (lock_cnt < L_MAX);
        lock_spent = (state == LOCKED) & (lock_cnt >= L_MAX);
        idle_dma   = dma_req & !lock_spent & ((starve_cnt == S_MAX) | !cpu_en);
        dma_win    = !reset & (lock_hold | idle_dma);
        cpu_win    = !reset & !dma_win & cpu_en;
        state_nx   = (lock_hold | (idle_dma & dma_lock)) ? LOCKED : IDLE;
        lock_nx    = lock_hold ? lock_cnt + 4'd1 : (idle_dma & dma_lock) ? 4'd1 : 4'd0;
        starve_nx  = lock_hold ? starve_cnt :
                     idle_dma ? 4'd0 :
                     (cpu_en & dma_req) ? ((starve_cnt >= S_MAX) ? S_MAX : starve_cnt + 4'd1) :
                     starve_cnt;
    end
    // arbitration state, counters and the registered DMA read return
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            lock_cnt   <= 4'd0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            lock_cnt   <= lock_nx;
            rvalid_q   <= dma_win & !dma_wr;
            if (dma_win & !dma_wr) rdata_q <= mem_rdata;
        end
    end
    assign mem_en     = dma_win | cpu_win;
    assign mem_wr_en  = dma_win ? dma_wr : cpu_win & cpu_wr_en;
    assign mem_addr   = dma_win ? dma_addr : cpu_win ? cpu_addr : '0;
    assign mem_wdata  = dma_win ? dma_wdata : cpu_win ? cpu_wdata : '0;
    assign cpu_rdata  = cpu_win ? mem_rdata : '0;
    assign cpu_stall  = dma_win & cpu_en;
    assign dma_gnt    = dma_win;
    assign dma_rvalid = !reset & rvalid_q;
    assign dma_rdata  = reset ? '0 : rdata_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed checks of the dmem arbiter against a behavioural dmem
module tb_dmem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_en, cpu_wr_en, dma_req, dma_wr, dma_lock;
    logic [7:0]  cpu_addr, dma_addr, mem_addr;
    logic [63:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic        cpu_stall, dma_gnt, dma_rvalid, mem_en, mem_wr_en;
    logic [63:0] mem [256];
    int          checks = 0;
    int          errors = 0;
    localparam logic [63:0] D1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] W1 = 64'h1111;
    localparam logic [63:0] W2 = 64'h2222;
    localparam logic [63:0] W3 = 64'h3333;
    localparam logic [63:0] N1 = 64'hCAFEF00D12345678;

    dmem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_en(cpu_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en && mem_wr_en) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ce, input logic cw, input logic [7:0] ca, input logic [63:0] cd,
                         input logic dr, input logic dw, input logic dl, input logic [7:0] da,
                         input logic [63:0] dd);
        cpu_en = ce; cpu_wr_en = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_wr = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset = 1'b1;
        drive(1, 1, 8'h05, 64'h55, 1, 1, 1, 8'h06, 64'h66);
        settle;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_gnt", dma_gnt, 0);
        chk("rst_rvalid", dma_rvalid, 0);
        tick;
        tick;
        reset = 1'b0;
        // CPU write then read back
        drive(1, 1, 8'h10, D1, 0, 0, 0, 0, 0);
        settle;
        chk("t1_wr_en", mem_wr_en, 1);
        chk("t1_addr", mem_addr, 8'h10);
        chk("t1_stall", cpu_stall, 0);
        tick;
        drive(1, 0, 8'h10, 0, 0, 0, 0, 0, 0);
        settle;
        chk("t1_rd_wr_en", mem_wr_en, 0);
        chk("t1_rdata", cpu_rdata, D1);
        tick;
        // DMA read alone
        drive(0, 0, 0, 0, 1, 0, 0, 8'h10, 0);
        settle;
        chk("t2_gnt", dma_gnt, 1);
        chk("t2_cpu_rdata", cpu_rdata, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle;
        chk("t2_rvalid", dma_rvalid, 1);
        chk("t2_rdata", dma_rdata, D1);
        tick;
        settle;
        chk("t2_rvalid_drop", dma_rvalid, 0);
        chk("t2_rdata_hold", dma_rdata, D1);
        tick;
        // starvation: DMA forced every 5th cycle
        drive(1, 0, 8'h20, 0, 1, 0, 0, 8'h30, 0);
        for (int i = 0; i < 10; i++) begin
            settle;
            chk($sformatf("t3_gnt_stall_%0d", i), {dma_gnt, cpu_stall}, (i % 5 == 4) ? 2'b11 : 2'b00);
            tick;
        end
        // lock: 8 locked grants, one CPU cycle, relock after 4 denials
        for (int i = 0; i < 14; i++) begin
            drive(i != 0, 0, 8'h20, 0, 1, 0, 1, 8'h30, 0);
            settle;
            chk($sformatf("t4_gnt_%0d", i), dma_gnt, (i < 8 || i >= 12) ? 1 : 0);
            chk($sformatf("t4_stall_%0d", i), cpu_stall, (i != 0 && (i < 8 || i >= 12)) ? 1 : 0);
            tick;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        // lock limit with idle CPU: one empty cycle then relock
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 1, 0, 1, 8'h30, 0);
            settle;
            chk($sformatf("t4b_gnt_en_%0d", i), {dma_gnt, mem_en}, (i == 8) ? 2'b00 : 2'b11);
            tick;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        // reset during a locked DMA write burst
        drive(0, 0, 0, 0, 1, 1, 1, 8'h40, W1);
        settle;
        chk("t5_gnt_a", dma_gnt, 1);
        tick;
        drive(0, 0, 0, 0, 1, 1, 1, 8'h40, W2);
        settle;
        chk("t5_gnt_b", dma_gnt, 1);
        chk("t5_no_rvalid_on_wr", dma_rvalid, 0);
        tick;
        reset = 1'b1;
        drive(0, 0, 0, 0, 1, 1, 1, 8'h40, W3);
        settle;
        chk("t5_rst_mem_en", mem_en, 0);
        chk("t5_rst_wr_en", mem_wr_en, 0);
        chk("t5_rst_gnt", dma_gnt, 0);
        tick;
        reset = 1'b0;
        drive(1, 0, 8'h40, 0, 1, 0, 1, 8'h50, 0);
        for (int i = 0; i < 5; i++) begin
            settle;
            if (i == 0) chk("t5_mem_kept", cpu_rdata, W2);
            chk($sformatf("t5_post_gnt_%0d", i), dma_gnt, (i == 4) ? 1 : 0);
            tick;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        // CPU write versus DMA read on the same address
        drive(1, 1, 8'h60, N1, 1, 0, 0, 8'h60, 0);
        settle;
        chk("t6_wr_en", mem_wr_en, 1);
        chk("t6_wdata", mem_wdata, N1);
        chk("t6_gnt", dma_gnt, 0);
        chk("t6_stall", cpu_stall, 0);
        tick;
        drive(0, 0, 0, 0, 1, 0, 0, 8'h60, 0);
        settle;
        chk("t6_gnt2", dma_gnt, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle;
        chk("t6_rvalid", dma_rvalid, 1);
        chk("t6_rdata", dma_rdata, N1);
        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port 256x64 data memory (dmem) between two requesters: the cardinal CPU data port and a DMA/NIC master port.
- Sits between the CPU's dmem_* pins and the dmem instance.
- The CPU has fixed priority. An anti-starvation counter guarantees the DMA port bounded latency.
- A lock mode gives the DMA port atomic multi-cycle access with a bounded hold time.

Parameters:
- ADDR_W, 8, dmem word-address width (memAddr).
- DATA_W, 64, dmem data width.
- STARVE_MAX, 4, consecutive DMA denials after which DMA is force-granted (1..15).
- LOCK_MAX, 8, maximum consecutive locked DMA grants (1..15).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_en  in  1  CPU access request (dmem_En).
- cpu_wr_en  in  1  CPU write qualifier (dmem_WrEn).
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_stall  out  1  CPU access not performed this cycle; CPU must hold its request.
- dma_req  in  1  DMA access request.
- dma_wr  in  1  DMA write qualifier.
- dma_lock  in  1  DMA requests grant retention on following cycles.
- dma_addr  in  ADDR_W  DMA word address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_rvalid  out  1  registered DMA read data valid.
- dma_rdata  out  DATA_W  registered DMA read data.
- mem_en  out  1  to dmem memEn.
- mem_wr_en  out  1  to dmem memWrEn.
- mem_addr  out  ADDR_W  to dmem memAddr.
- mem_wdata  out  DATA_W  to dmem dataIn.
- mem_rdata  in  DATA_W  from dmem dataOut.

Behaviour:

dmem timing model:
- Asynchronous read: mem_rdata is valid in the same cycle as mem_addr.
- Write occurs on the rising clk edge while mem_en & mem_wr_en.

Grant decision:
- Combinational from the current inputs and registered state.
- Exactly one winner or none per cycle.
- mem_* are driven from the winner. With no winner: mem_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.

States (registered): IDLE, LOCKED. Counters: starve_cnt (4b), lock_cnt (4b).

IDLE:
- If dma_req & (starve_cnt==STARVE_MAX), or dma_req & !cpu_en: DMA wins. cpu_stall=cpu_en. starve_cnt<=0.
  - If dma_lock is also 1: go to LOCKED, lock_cnt<=1.
- Else if cpu_en: CPU wins, cpu_stall=0.
  - If dma_req: starve_cnt<=starve_cnt+1, saturating at STARVE_MAX.
- Else: idle, no grant.

LOCKED:
- If dma_req & dma_lock & (lock_cnt<LOCK_MAX): DMA wins. lock_cnt<=lock_cnt+1. cpu_stall=cpu_en.
- Otherwise: return to IDLE and evaluate the IDLE rules in the same cycle, with one exception. If lock_cnt==LOCK_MAX, DMA is ineligible this cycle, so the CPU wins if cpu_en; if !cpu_en, there is no grant.
- lock_cnt<=0 on exit.

Outputs:
- cpu_rdata = mem_rdata whenever the CPU wins; otherwise holds 0.
- dma_gnt = 1 exactly in the cycles where DMA wins.
- dma_rvalid registers (DMA wins & !dma_wr). It is a 1-cycle pulse in the following cycle.
- dma_rdata is captured from mem_rdata on that same edge and holds until the next DMA read.
- A DMA write never raises dma_rvalid.

Boundaries:
- A write and a read never share a cycle; only the winner's wr_en reaches dmem.
- dma_lock with dma_req=0 is ignored.
- Lock is honoured only once DMA has been granted.
- Saturated starve_cnt never wraps.
- LOCK_MAX reached: a forced single-cycle release even if the CPU is idle.

Reset:
- While reset=1, all outputs are 0, including cpu_stall, dma_gnt, mem_en and dma_rvalid, regardless of requests.
- State<=IDLE; starve_cnt, lock_cnt, dma_rdata <= 0.
- Reset asserted mid-LOCK aborts the lock with no partial write issued in the reset cycle.

Test Plan:
1. CPU only: cpu_en=1, cpu_wr_en=1, addr=0x10, wdata=0x0123456789ABCDEF; next cycle read 0x10 -> mem_wr_en pulses once, cpu_stall=0, cpu_rdata=0x0123456789ABCDEF same cycle.
2. DMA only: dma_req=1, dma_wr=0, addr=0x10 -> dma_gnt=1 that cycle; dma_rvalid=1 next cycle with dma_rdata=0x0123456789ABCDEF; dma_rvalid=0 after.
3. Starvation: cpu_en and dma_req held high continuously, STARVE_MAX=4 -> CPU wins 4 cycles, DMA wins the 5th (cpu_stall=1 that cycle only), pattern repeats every 5 cycles.
4. Lock: dma_req=dma_lock=1 for 12 cycles with cpu_en=1, LOCK_MAX=8 -> DMA granted 8 consecutive cycles, CPU granted the 9th, then DMA resumes lock (cpu_en held) only via the starvation rule after 4 denials.
5. Reset mid-lock: assert reset on 3rd locked cycle with dma_wr=1 -> mem_en=0 during reset, no write to dmem, state IDLE with counters 0 after release.
6. Simultaneous request, CPU write vs DMA read same address, starve_cnt=0 -> CPU write lands; DMA read granted next cycle returns the new data.
